// File: rtl/l1_dcache_pkg.sv
// Shared types and geometry constants for the direct-mapped L1 data cache.
`timescale 1ns/1ps
package cache_types;

  typedef enum logic [1:0] {IDLE, WB, ALLOC} cache_state_t;

  localparam int LINE_W     = 256;
  localparam int LINE_BYTES = LINE_W / 8;
  localparam int OFFSET_W   = 5;
  localparam int WORD_SEL_W = 3;

  typedef logic [LINE_W-1:0] line_t;

endpackage

// File: rtl/l1_dcache_data_array.sv
// Line storage for the L1 data cache: per-byte write enables, combinational read.
`timescale 1ns/1ps
module cache_data_array
  import cache_types::*;
#(
  parameter int S_INDEX = 3
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [S_INDEX-1:0]    index_i,
  input  logic [LINE_BYTES-1:0] be_i,
  input  line_t                 wdata_i,
  output line_t                 rdata_o
);

  line_t lines_q [2**S_INDEX];

  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int b = 0; b < LINE_BYTES; b++) begin
        if (be_i[b]) lines_q[index_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  assign rdata_o = lines_q[index_i];

endmodule

// File: rtl/l1_dcache.sv
// Direct-mapped, write-back, write-allocate L1 data cache between the core word
// interface and a single-beat 256-bit physical memory port.
`timescale 1ns/1ps
module l1_dcache
  import cache_types::*;
#(
  parameter int S_INDEX = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   mem_address,
  input  logic          mem_read,
  input  logic          mem_write,
  input  logic [3:0]    mem_byte_enable,
  input  logic [31:0]   mem_wdata,
  output logic [31:0]   mem_rdata,
  output logic          mem_resp,
  output logic [31:0]   pmem_address,
  output logic          pmem_read,
  output logic          pmem_write,
  output logic [255:0]  pmem_wdata,
  input  logic [255:0]  pmem_rdata,
  input  logic          pmem_resp
);

  localparam int TAG_W = 27 - S_INDEX;
  localparam int NSETS = 2**S_INDEX;

  cache_state_t state_q, state_d;

  logic [TAG_W-1:0] tag_q [NSETS];
  logic [NSETS-1:0] valid_q;
  logic [NSETS-1:0] dirty_q;

  logic [S_INDEX-1:0]    idx;
  logic [TAG_W-1:0]      req_tag;
  logic [WORD_SEL_W-1:0] wsel;
  line_t                 line_rd;
  line_t                 line_wd;
  logic [LINE_BYTES-1:0] line_be;
  logic                  req;
  logic                  hit;
  logic                  hit_wr;
  logic                  fill;
  logic                  arr_we;
  logic                  unused_addr_lsb;

  assign idx             = mem_address[OFFSET_W +: S_INDEX];
  assign req_tag         = mem_address[31 -: TAG_W];
  assign wsel            = mem_address[2 +: WORD_SEL_W];
  assign unused_addr_lsb = ^mem_address[1:0];

  assign req    = mem_read | mem_write;
  assign hit    = valid_q[idx] && (tag_q[idx] == req_tag);
  // A simultaneous read+write is served as a write, so only mem_write matters here.
  assign hit_wr = (state_q == IDLE) && mem_write && hit;
  assign fill   = (state_q == ALLOC) && pmem_resp;
  assign arr_we = !rst && (hit_wr || fill);

  assign line_be = fill ? {LINE_BYTES{1'b1}}
                        : (LINE_BYTES'(mem_byte_enable) << {wsel, 2'b00});
  assign line_wd = fill ? pmem_rdata : {8{mem_wdata}};

  cache_data_array #(.S_INDEX(S_INDEX)) u_data (
    .clk     (clk),
    .we_i    (arr_we),
    .index_i (idx),
    .be_i    (line_be),
    .wdata_i (line_wd),
    .rdata_o (line_rd)
  );

  assign mem_rdata = line_rd[{wsel, 5'b00000} +: 32];

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    mem_resp     = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (hit)                              mem_resp = 1'b1;
          else if (valid_q[idx] && dirty_q[idx]) state_d  = WB;
          else                                   state_d  = ALLOC;
        end
      end
      WB: begin
        pmem_write   = 1'b1;
        pmem_address = {tag_q[idx], idx, 5'b00000};
        pmem_wdata   = line_rd;
        if (pmem_resp) state_d = ALLOC;
      end
      ALLOC: begin
        pmem_read    = 1'b1;
        pmem_address = {req_tag, idx, 5'b00000};
        if (pmem_resp) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Data and tags survive reset; only the state bits are cleared.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if (hit_wr)                          dirty_q[idx] <= 1'b1;
      if ((state_q == WB) && pmem_resp)    dirty_q[idx] <= 1'b0;
      if (fill) begin
        valid_q[idx] <= 1'b1;
        dirty_q[idx] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && fill) tag_q[idx] <= req_tag;
  end

endmodule

// File: tb/tb_l1_dcache.sv
// Self-checking bench for l1_dcache: directed scenarios plus randomized traffic
// against a set-level reference model and a behavioural physical memory.
`timescale 1ns/1ps
module tb_l1_dcache;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [31:0]  mem_address = '0;
  logic         mem_read = 1'b0;
  logic         mem_write = 1'b0;
  logic [3:0]   mem_byte_enable = '0;
  logic [31:0]  mem_wdata = '0;
  logic [31:0]  mem_rdata;
  logic         mem_resp;
  logic [31:0]  pmem_address;
  logic         pmem_read;
  logic         pmem_write;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata = '0;
  logic         pmem_resp = 1'b0;

  int n_cmp = 0;
  int n_fail = 0;
  int resp_delay = 3;
  bit proto_err = 1'b0;

  typedef struct {
    bit           wr;
    logic [31:0]  addr;
    logic [255:0] data;
  } ev_t;

  ev_t obs_q[$];
  ev_t exp_q[$];

  bit           ref_valid [8];
  bit           ref_dirty [8];
  logic [31:0]  ref_tag   [8];
  logic [31:0]  ref_words [8][8];
  logic [255:0] ref_mem [logic [31:0]];
  logic [255:0] pm      [logic [31:0]];

  l1_dcache #(.S_INDEX(3)) dut (
    .clk             (clk),
    .rst             (rst),
    .mem_address     (mem_address),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_byte_enable (mem_byte_enable),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata),
    .mem_resp        (mem_resp),
    .pmem_address    (pmem_address),
    .pmem_read       (pmem_read),
    .pmem_write      (pmem_write),
    .pmem_wdata      (pmem_wdata),
    .pmem_rdata      (pmem_rdata),
    .pmem_resp       (pmem_resp)
  );

  initial forever #5 clk = ~clk;

  // Untouched memory: line at 0x40 holds word i = i; other lines are offset by address.
  function automatic logic [255:0] init_line(input logic [31:0] la);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = ((la - 32'h40) << 8) | 32'(w);
    return l;
  endfunction

  // Physical memory: answers an active request after resp_delay cycles.
  initial begin : responder
    int  cnt;
    ev_t ev;
    cnt = 0;
    forever begin
      @(posedge clk); #1;
      if (pmem_resp) begin
        pmem_resp = 1'b0;
        cnt = 0;
      end
      if (pmem_read || pmem_write) begin
        cnt++;
        if (cnt == resp_delay) begin
          ev.wr   = pmem_write;
          ev.addr = pmem_address;
          if (pmem_write) begin
            ev.data = pmem_wdata;
            pm[pmem_address] = pmem_wdata;
          end else begin
            ev.data = pm.exists(pmem_address) ? pm[pmem_address] : init_line(pmem_address);
            pmem_rdata = ev.data;
          end
          obs_q.push_back(ev);
          pmem_resp = 1'b1;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) begin
      ref_valid[i] = 1'b0;
      ref_dirty[i] = 1'b0;
    end
  endfunction

  function automatic logic [255:0] ref_line(input int s);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = ref_words[s][w];
    return l;
  endfunction

  // One core access at the level of sets and lines: expected pmem traffic, latency, read word.
  function automatic void model_access(input logic [31:0] a, input bit wr, input logic [3:0] be,
                                       input logic [31:0] wd, input int d,
                                       output logic [31:0] rd, output int cyc);
    int          s;
    int          w;
    logic [31:0] t;
    logic [31:0] la;
    ev_t         e;
    s  = int'((a >> 5) & 32'h7);
    w  = int'((a >> 2) & 32'h7);
    t  = a >> 8;
    la = (a >> 5) << 5;
    exp_q.delete();
    cyc = 1;
    if (!(ref_valid[s] && ref_tag[s] == t)) begin
      if (ref_valid[s] && ref_dirty[s]) begin
        e.wr   = 1'b1;
        e.addr = (ref_tag[s] << 8) | (32'(s) << 5);
        e.data = ref_line(s);
        ref_mem[e.addr] = e.data;
        exp_q.push_back(e);
        cyc += d;
      end
      e.wr   = 1'b0;
      e.addr = la;
      e.data = ref_mem.exists(la) ? ref_mem[la] : init_line(la);
      exp_q.push_back(e);
      for (int k = 0; k < 8; k++) ref_words[s][k] = e.data[k*32 +: 32];
      ref_valid[s] = 1'b1;
      ref_dirty[s] = 1'b0;
      ref_tag[s]   = t;
      cyc += d + 1;
    end
    if (wr) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) ref_words[s][w][b*8 +: 8] = wd[b*8 +: 8];
      end
      ref_dirty[s] = 1'b1;
    end
    rd = ref_words[s][w];
  endfunction

  task automatic access(input logic [31:0] a, input bit r, input bit w, input logic [3:0] be,
                        input logic [31:0] wd, output logic [31:0] rd, output int cyc,
                        output bit to);
    obs_q.delete();
    @(posedge clk); #1;
    mem_address     = a;
    mem_read        = r;
    mem_write       = w;
    mem_byte_enable = be;
    mem_wdata       = wd;
    cyc = 0;
    to  = 1'b0;
    rd  = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (pmem_read && pmem_write) proto_err = 1'b1;
      if (mem_resp) begin
        rd = mem_rdata;
        break;
      end
      if (cyc > 200) begin
        to = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (mem_resp !== 1'b0) begin n_fail++; $display("FAIL reset_mem_resp: got %b want 0", mem_resp); end
    n_cmp++; if (pmem_read !== 1'b0) begin n_fail++; $display("FAIL reset_pmem_read: got %b want 0", pmem_read); end
    n_cmp++; if (pmem_write !== 1'b0) begin n_fail++; $display("FAIL reset_pmem_write: got %b want 0", pmem_write); end
    n_cmp++; if (pmem_address !== 32'h0) begin n_fail++; $display("FAIL reset_pmem_address: got %h want 0", pmem_address); end
    n_cmp++; if (pmem_wdata !== 256'h0) begin n_fail++; $display("FAIL reset_pmem_wdata: got %h want 0", pmem_wdata); end
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_directed();
    logic [31:0] rd, erd;
    int          cyc, ecyc;
    bit          to;
    resp_delay = 3;

    model_access(32'h44, 1'b0, 4'hf, 32'h0, 3, erd, ecyc);
    access(32'h44, 1'b1, 1'b0, 4'hf, 32'h0, rd, cyc, to);
    n_cmp++; if (to !== 1'b0) begin n_fail++; $display("FAIL fill_timeout: got %b want 0", to); end
    n_cmp++; if (obs_q.size() != 1) begin n_fail++; $display("FAIL fill_count: got %0d want 1", obs_q.size()); end
    else begin
      n_cmp++;
      if (obs_q[0].wr !== 1'b0 || obs_q[0].addr !== 32'h40) begin
        n_fail++; $display("FAIL fill_addr: got wr=%b %h want read 00000040", obs_q[0].wr, obs_q[0].addr);
      end
    end
    n_cmp++; if (rd !== 32'h1) begin n_fail++; $display("FAIL fill_rdata: got %h want 00000001", rd); end
    n_cmp++; if (cyc != 5) begin n_fail++; $display("FAIL fill_latency: got %0d want 5", cyc); end

    model_access(32'h48, 1'b0, 4'hf, 32'h0, 3, erd, ecyc);
    access(32'h48, 1'b1, 1'b0, 4'hf, 32'h0, rd, cyc, to);
    n_cmp++; if (cyc != 1) begin n_fail++; $display("FAIL hit_latency: got %0d want 1", cyc); end
    n_cmp++; if (rd !== 32'h2) begin n_fail++; $display("FAIL hit_rdata: got %h want 00000002", rd); end
    n_cmp++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL hit_pmem: got %0d transfers want 0", obs_q.size()); end

    model_access(32'h44, 1'b1, 4'b0100, 32'h00AB0000, 3, erd, ecyc);
    access(32'h44, 1'b0, 1'b1, 4'b0100, 32'h00AB0000, rd, cyc, to);
    n_cmp++; if (cyc != 1 || obs_q.size() != 0) begin n_fail++; $display("FAIL write_hit: got %0d cycles %0d transfers want 1 0", cyc, obs_q.size()); end
    model_access(32'h44, 1'b0, 4'hf, 32'h0, 3, erd, ecyc);
    access(32'h44, 1'b1, 1'b0, 4'hf, 32'h0, rd, cyc, to);
    n_cmp++; if (rd !== 32'h00AB0001) begin n_fail++; $display("FAIL write_readback: got %h want 00ab0001", rd); end

    model_access(32'h140, 1'b0, 4'hf, 32'h0, 3, erd, ecyc);
    access(32'h140, 1'b1, 1'b0, 4'hf, 32'h0, rd, cyc, to);
    n_cmp++; if (obs_q.size() != 2) begin n_fail++; $display("FAIL evict_count: got %0d want 2", obs_q.size()); end
    else begin
      n_cmp++;
      if (obs_q[0].wr !== 1'b1 || obs_q[0].addr !== 32'h40 || obs_q[0].data[63:32] !== 32'h00AB0001) begin
        n_fail++; $display("FAIL evict_wb: got wr=%b %h word1=%h want write 00000040 00ab0001",
                           obs_q[0].wr, obs_q[0].addr, obs_q[0].data[63:32]);
      end
      n_cmp++;
      if (obs_q[1].wr !== 1'b0 || obs_q[1].addr !== 32'h140) begin
        n_fail++; $display("FAIL evict_alloc: got wr=%b %h want read 00000140", obs_q[1].wr, obs_q[1].addr);
      end
    end
    n_cmp++; if (cyc != 8) begin n_fail++; $display("FAIL evict_latency: got %0d want 8", cyc); end
    n_cmp++; if (rd !== 32'h00010000) begin n_fail++; $display("FAIL evict_rdata: got %h want 00010000", rd); end
    n_cmp++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL directed_proto: got %b want 0", proto_err); end
  endtask

  task automatic test_reset_mid_alloc();
    logic [31:0] rd, erd;
    int          cyc, ecyc;
    bit          to;
    resp_delay = 50;
    obs_q.delete();
    @(posedge clk); #1;
    mem_address     = 32'h44;
    mem_read        = 1'b1;
    mem_byte_enable = 4'hf;
    repeat (3) @(negedge clk);
    n_cmp++; if (pmem_read !== 1'b1 || pmem_address !== 32'h40) begin n_fail++; $display("FAIL abort_alloc_entered: got %b %h want 1 00000040", pmem_read, pmem_address); end
    @(posedge clk); #1;
    rst      = 1'b1;
    mem_read = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (pmem_read !== 1'b0 || pmem_write !== 1'b0) begin n_fail++; $display("FAIL abort_drop: got read=%b write=%b want 0 0", pmem_read, pmem_write); end
    n_cmp++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL abort_transfers: got %0d want 0", obs_q.size()); end
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();

    resp_delay = 3;
    model_access(32'h44, 1'b0, 4'hf, 32'h0, 3, erd, ecyc);
    access(32'h44, 1'b1, 1'b0, 4'hf, 32'h0, rd, cyc, to);
    n_cmp++; if (cyc != 5 || obs_q.size() != 1) begin n_fail++; $display("FAIL abort_remiss: got %0d cycles %0d transfers want 5 1", cyc, obs_q.size()); end
    n_cmp++; if (rd !== 32'h00AB0001) begin n_fail++; $display("FAIL abort_rdata: got %h want 00ab0001", rd); end
  endtask

  task automatic test_long_stall();
    logic [31:0] rd, erd;
    int          cyc, ecyc;
    bit          got;
    resp_delay = 11;
    model_access(32'h200, 1'b0, 4'hf, 32'h0, 11, erd, ecyc);
    obs_q.delete();
    @(posedge clk); #1;
    mem_address     = 32'h200;
    mem_read        = 1'b1;
    mem_byte_enable = 4'hf;
    cyc = 0;
    got = 1'b0;
    rd  = '0;
    while (!got && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (mem_resp) begin
        got = 1'b1;
        rd  = mem_rdata;
      end else if (cyc >= 2 && cyc <= 11) begin
        n_cmp++;
        if (pmem_read !== 1'b1 || pmem_address !== 32'h200 || pmem_resp !== 1'b0) begin
          n_fail++; $display("FAIL stall_hold: cycle %0d got read=%b addr=%h want 1 00000200", cyc, pmem_read, pmem_address);
        end
      end
    end
    @(posedge clk); #1;
    mem_read = 1'b0;
    n_cmp++; if (got !== 1'b1) begin n_fail++; $display("FAIL stall_timeout: got no mem_resp want mem_resp"); end
    n_cmp++; if (cyc != ecyc) begin n_fail++; $display("FAIL stall_latency: got %0d want %0d", cyc, ecyc); end
    n_cmp++; if (rd !== erd) begin n_fail++; $display("FAIL stall_rdata: got %h want %h", rd, erd); end
  endtask

  task automatic test_random();
    logic [23:0] tags [4];
    logic [31:0] a, wd, rd, erd;
    logic [3:0]  be;
    int          kind, d, cyc, ecyc, n;
    bit          to;
    tags[0] = 24'h000000;
    tags[1] = 24'h000001;
    tags[2] = 24'h00ABCD;
    tags[3] = 24'h800000;
    for (int it = 0; it < 300; it++) begin
      a    = {tags[$urandom_range(0, 3)], 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 2'b00};
      kind = $urandom_range(0, 2);
      be   = 4'($urandom_range(0, 15));
      wd   = $urandom;
      d    = $urandom_range(1, 4);
      resp_delay = d;
      model_access(a, kind != 0, be, wd, d, erd, ecyc);
      access(a, kind != 1, kind != 0, be, wd, rd, cyc, to);
      n_cmp++; if (to !== 1'b0) begin n_fail++; $display("FAIL rand_timeout: it %0d addr %h", it, a); end
      n_cmp++; if (cyc != ecyc) begin n_fail++; $display("FAIL rand_latency: it %0d addr %h got %0d want %0d", it, a, cyc, ecyc); end
      n_cmp++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rand_count: it %0d got %0d want %0d", it, obs_q.size(), exp_q.size()); end
      n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int k = 0; k < n; k++) begin
        n_cmp++;
        if (obs_q[k].wr !== exp_q[k].wr || obs_q[k].addr !== exp_q[k].addr ||
            (obs_q[k].wr && obs_q[k].data !== exp_q[k].data)) begin
          n_fail++; $display("FAIL rand_xfer: it %0d #%0d got wr=%b %h %h want wr=%b %h %h", it, k,
                             obs_q[k].wr, obs_q[k].addr, obs_q[k].data, exp_q[k].wr, exp_q[k].addr, exp_q[k].data);
        end
      end
      if (kind == 0) begin
        n_cmp++; if (rd !== erd) begin n_fail++; $display("FAIL rand_rdata: it %0d addr %h got %h want %h", it, a, rd, erd); end
      end
    end
    n_cmp++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL rand_proto: read and write asserted together"); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_reset_mid_alloc();
    test_long_stall();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
